// File: rtl/max_pooling_mult.sv
// 1x2 float32 max-pooling stage: each adjacent input pair reduces to one max, registered once.
// Optional fused ReLU on the pooled result when MAXPOOL_RELU_EN is defined.
module max_pooling_mult #(
  parameter int ROWS    = 4,
  parameter int IN_COLS = 92,
  parameter int DW      = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           valid_i,
  input  logic [ROWS*IN_COLS*DW-1:0]     multi_input_data,
  output logic                           valid_o,
  output logic [ROWS*(IN_COLS/2)*DW-1:0] multi_output_data
);

  localparam int N_OUT = ROWS * (IN_COLS / 2);

  logic [N_OUT*DW-1:0] max_next;

  generate
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_pair
      logic [DW-1:0] a_val;
      logic [DW-1:0] b_val;
      logic          a_wins;
      logic [DW-1:0] max_val;

      assign a_val = multi_input_data[(2*gi)*DW +: DW];
      assign b_val = multi_input_data[(2*gi+1)*DW +: DW];

      // Sign-magnitude ordering; a only wins when strictly greater, so ties return b.
      always_comb begin
        a_wins = 1'b0;
        case ({a_val[DW-1], b_val[DW-1]})
          2'b00:   a_wins = (a_val[DW-2:0] > b_val[DW-2:0]);
          2'b11:   a_wins = (a_val[DW-2:0] < b_val[DW-2:0]);
          2'b01:   a_wins = 1'b1;
          default: a_wins = 1'b0;
        endcase
      end

      assign max_val = a_wins ? a_val : b_val;

`ifdef MAXPOOL_RELU_EN
      assign max_next[gi*DW +: DW] = max_val[DW-1] ? '0 : max_val;
`else
      assign max_next[gi*DW +: DW] = max_val;
`endif
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_o           <= 1'b0;
      multi_output_data <= '0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        multi_output_data <= max_next;
      end
    end
  end

endmodule

// File: tb/tb_max_pooling_mult.sv
// Scoreboard bench for max_pooling_mult: directed pair patterns, hold, reset and ReLU-aware expectations.
module tb_max_pooling_mult;

  localparam int ROWS    = 4;
  localparam int IN_COLS = 92;
  localparam int DW      = 32;
  localparam int NI      = ROWS * IN_COLS;
  localparam int NO      = ROWS * (IN_COLS / 2);

  localparam logic [31:0] T_LO [8] = '{32'h3F800000, 32'h40000000, 32'hBF800000, 32'h3F800000,
                                       32'hC0000000, 32'h7FC00000, 32'h00000001, 32'h80000000};
  localparam logic [31:0] T_HI [8] = '{32'h40000000, 32'h3F800000, 32'h3F800000, 32'hBF800000,
                                       32'hBF800000, 32'h7F800000, 32'h00000000, 32'h80000001};
  localparam logic [31:0] T_EX [8] = '{32'h40000000, 32'h40000000, 32'h3F800000, 32'h3F800000,
                                       32'hBF800000, 32'h7FC00000, 32'h00000001, 32'h80000000};

  logic             clk;
  logic             reset;
  logic             valid_i;
  logic [NI*DW-1:0] din;
  logic             valid_o;
  logic [NO*DW-1:0] dout;

  logic [NO*DW-1:0] exp_q [$];
  logic [NO*DW-1:0] next_exp;
  logic [NO*DW-1:0] last_exp;
  logic [NO*DW-1:0] zero_vec;
  int checks;
  int errors;
  int beats;

  max_pooling_mult #(.ROWS(ROWS), .IN_COLS(IN_COLS), .DW(DW)) dut (
    .clk              (clk),
    .reset            (reset),
    .valid_i          (valid_i),
    .multi_input_data (din),
    .valid_o          (valid_o),
    .multi_output_data(dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] relu(input logic [31:0] x);
`ifdef MAXPOOL_RELU_EN
    return x[31] ? 32'h0 : x;
`else
    return x;
`endif
  endfunction

  // in[2j] = lo, in[2j+1] = hi for every pair
  task automatic set_pairs(input logic [31:0] lo, input logic [31:0] hi, input logic [31:0] ex);
    for (int j = 0; j < NO; j++) begin
      din[(2*j)*DW +: DW]   = lo;
      din[(2*j+1)*DW +: DW] = hi;
      next_exp[j*DW +: DW]  = relu(ex);
    end
  endtask

  task automatic set_table();
    for (int j = 0; j < NO; j++) begin
      din[(2*j)*DW +: DW]   = T_LO[j % 8];
      din[(2*j+1)*DW +: DW] = T_HI[j % 8];
      next_exp[j*DW +: DW]  = relu(T_EX[j % 8]);
    end
  endtask

  task automatic issue();
    valid_i = 1'b1;
    exp_q.push_back(next_exp);
    last_exp = next_exp;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic [NO*DW-1:0] ev, input logic evalid);
    int bad;
    bad = -1;
    for (int j = 0; j < NO; j++)
      if (bad < 0 && dout[j*DW +: DW] !== ev[j*DW +: DW]) bad = j;
    checks++;
    if (bad >= 0 || valid_o !== evalid) begin
      errors++;
      if (bad < 0) bad = 0;
      $display("FAIL %s: out[%0d]=%h valid_o=%b, required out[%0d]=%h valid_o=%b",
               name, bad, dout[bad*DW +: DW], valid_o, bad, ev[bad*DW +: DW], evalid);
    end else begin
      $display("check %s: out[0]=%h valid_o=%b", name, dout[DW-1:0], valid_o);
    end
  endtask

  // Monitor: every valid beat is popped from the scoreboard and compared in full.
  always @(negedge clk) begin
    if (!reset && valid_o) begin
      logic [NO*DW-1:0] ev;
      int bad;
      checks++;
      beats++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat%0d: valid_o=1 with no expected result queued", beats);
      end else begin
        ev = exp_q.pop_front();
        bad = -1;
        for (int j = 0; j < NO; j++)
          if (bad < 0 && dout[j*DW +: DW] !== ev[j*DW +: DW]) bad = j;
        if (bad >= 0) begin
          errors++;
          $display("FAIL beat%0d: out[%0d]=%h, required %h", beats, bad,
                   dout[bad*DW +: DW], ev[bad*DW +: DW]);
        end else begin
          $display("beat %0d: out[0]=%h out[%0d]=%h", beats, dout[DW-1:0], NO-1, dout[(NO-1)*DW +: DW]);
        end
      end
    end
  end

  initial begin
    checks   = 0;
    errors   = 0;
    beats    = 0;
    zero_vec = '0;
    next_exp = '0;
    last_exp = '0;
    reset    = 1'b1;
    valid_i  = 1'b1;
    set_pairs(32'h8C000000, 32'h0C000000, 32'h0C000000);

    // Valid data presented while reset is held must not reach the output.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_out("in_reset", zero_vec, 1'b0);
    end

    reset = 1'b0;
    issue();
    valid_i = 1'b0;
    set_pairs(32'h11111111, 32'h22222222, 32'h22222222);
    @(posedge clk);
    #1;
    check_out("hold_valid_low", last_exp, 1'b0);

    // Back-to-back beats.
    set_pairs(32'h0B000000, 32'h0A000000, 32'h0B000000);
    issue();
    set_pairs(32'hC0000000, 32'hBF800000, 32'hBF800000);
    issue();
    set_pairs(32'h00000000, 32'h80000000, 32'h00000000);
    issue();
    set_pairs(32'h80000000, 32'h00000000, 32'h00000000);
    issue();
    set_table();
    issue();

    // Async reset with a result on the output and a fresh valid input pending.
    set_pairs(32'h3F800000, 32'h40000000, 32'h40000000);
    valid_i = 1'b1;
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_out("async_reset_clear", zero_vec, 1'b0);
    @(posedge clk);
    #1;
    check_out("reset_discard", zero_vec, 1'b0);
    reset = 1'b0;
    issue();
    valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_out("final_hold", last_exp, 1'b0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results still queued, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded 20000 time units, required completion");
    $fatal(1);
  end

endmodule
